// File: rtl/cronometro_contador_pkg.sv
// Shared definitions for the stopwatch time base: FSM encoding, BCD digit width
// and the position of each digit inside the packed MM:SS.cc word.
package cronometro_contador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int N_DIGITS = 6;
  localparam int TIME_W = DIGIT_W * N_DIGITS;

  // Digit offsets inside time_bcd = {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
  localparam int CS_U_OFS  = 0;
  localparam int CS_T_OFS  = 4;
  localparam int SEC_U_OFS = 8;
  localparam int SEC_T_OFS = 12;
  localparam int MIN_U_OFS = 16;
  localparam int MIN_T_OFS = 20;

  localparam logic [DIGIT_W-1:0] BCD_NINE   = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_T_LAST = 4'd5;

endpackage

// File: rtl/cronometro_contador_bcd_digito.sv
// One BCD digit: counts 0..terminal when enabled, wraps to 0 and raises a
// combinational carry into the next digit on the wrapping increment.
module cronometro_contador_bcd_digito
  import cronometro_contador_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [DIGIT_W-1:0] terminal,
  output logic [DIGIT_W-1:0] q,
  output logic               at_term,
  output logic               carry_out
);

  assign at_term   = (q == terminal);
  assign carry_out = en & at_term;

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_term ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/cronometro_contador.sv
// Stopwatch MM:SS.cc BCD counter driven by a sampled 100 Hz tick level.
// Optional lap/freeze display is built when CRONOMETRO_LAP_EN is defined.
module cronometro_contador
  import cronometro_contador_pkg::*;
#(
  parameter int MIN_LIMIT = 59,
  parameter bit WRAP_STOP = 1'b0
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              start_stop,
  input  logic              clear,
  input  logic              lap,
  output logic [TIME_W-1:0] time_bcd,
  output logic              running,
  output logic              wrap,
  output logic              lap_active
);

  localparam logic [DIGIT_W-1:0] LIM_T = 4'(MIN_LIMIT / 10);
  localparam logic [DIGIT_W-1:0] LIM_U = 4'(MIN_LIMIT % 10);

  state_t state, next_state;
  logic tick_q, tick_rise, count_en, at_max, inc, wrap_hit, cnt_clr;
  logic running_d, wrap_d;
  logic [N_DIGITS-1:0] at_term, carry, en_chain;
  logic [DIGIT_W-1:0] term [N_DIGITS];
  logic [TIME_W-1:0] live;
  logic unused_carry;

  // tick_q resets high so a tick_in already high at reset release is no edge
  always_ff @(posedge clk_in) begin
    if (rst) tick_q <= 1'b1;
    else     tick_q <= tick_in;
  end

  assign tick_rise = tick_in & ~tick_q;
  assign count_en  = (state == ST_RUNNING) & tick_rise;
  assign at_max    = &at_term;
  assign wrap_hit  = count_en & at_max;
  assign inc       = count_en & ~(WRAP_STOP & at_max);
  assign cnt_clr   = rst | clear;
  assign en_chain  = {carry[N_DIGITS-2:0], inc};
  assign unused_carry = carry[N_DIGITS-1];

  // Minute units only run to LIM_U once the tens digit reaches LIM_T
  always_comb begin
    term[0] = BCD_NINE;
    term[1] = BCD_NINE;
    term[2] = BCD_NINE;
    term[3] = SEC_T_LAST;
    term[4] = (live[MIN_T_OFS +: DIGIT_W] == LIM_T) ? LIM_U : BCD_NINE;
    term[5] = LIM_T;
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    cronometro_contador_bcd_digito u_digit (
      .clk       (clk_in),
      .clr       (cnt_clr),
      .en        (en_chain[i]),
      .terminal  (term[i]),
      .q         (live[i*DIGIT_W +: DIGIT_W]),
      .at_term   (at_term[i]),
      .carry_out (carry[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = ST_IDLE;
    end else if (start_stop) begin
      case (state)
        ST_IDLE:    next_state = ST_RUNNING;
        ST_RUNNING: next_state = ST_PAUSED;
        ST_PAUSED:  next_state = ST_RUNNING;
        default:    next_state = ST_IDLE;
      endcase
    end else if (WRAP_STOP && wrap_hit) begin
      next_state = ST_PAUSED;
    end
  end

  always_comb begin
    running_d = (next_state == ST_RUNNING);
    wrap_d    = wrap_hit & ~clear;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      running <= running_d;
      wrap    <= wrap_d;
    end
  end

`ifdef CRONOMETRO_LAP_EN
  logic [TIME_W-1:0] snap;

  always_ff @(posedge clk_in) begin
    if (cnt_clr) begin
      lap_active <= 1'b0;
      snap       <= '0;
    end else if (lap) begin
      if (state == ST_RUNNING && !lap_active) begin
        snap       <= live;
        lap_active <= 1'b1;
      end else if (state != ST_IDLE) begin
        lap_active <= 1'b0;
      end
    end
  end

  assign time_bcd = lap_active ? snap : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign time_bcd   = live;
`endif

endmodule

// File: tb/tb_cronometro_contador.sv
// Directed bench for cronometro_contador: three instances (default limits, and
// MIN_LIMIT=1 with roll-over and with saturation) share one stimulus stream.
module tb_cronometro_contador;

  localparam int W = 29; // {dut[1:0], lap_active, wrap, running, time_bcd[23:0]}

  logic clk_in = 1'b0;
  logic rst, tick_in, start_stop, clear, lap;
  logic [23:0] time_a, time_b, time_c;
  logic running_a, running_b, running_c;
  logic wrap_a, wrap_b, wrap_c;
  logic lap_active_a, lap_active_b, lap_active_c;

  logic [W-1:0] exp_q[$];
  string name_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] mon_e;
  logic [26:0] mon_act;
  string mon_n;

  always #10 clk_in = ~clk_in;

  cronometro_contador u_dut_a (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap), .time_bcd(time_a), .running(running_a),
    .wrap(wrap_a), .lap_active(lap_active_a)
  );

  cronometro_contador #(.MIN_LIMIT(1), .WRAP_STOP(1'b0)) u_dut_b (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap), .time_bcd(time_b), .running(running_b),
    .wrap(wrap_b), .lap_active(lap_active_b)
  );

  cronometro_contador #(.MIN_LIMIT(1), .WRAP_STOP(1'b1)) u_dut_c (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .lap(lap), .time_bcd(time_c), .running(running_c),
    .wrap(wrap_c), .lap_active(lap_active_c)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(input logic [1:0] dut, input logic [23:0] t,
                            input logic run, input logic wr, input logic la,
                            input string name);
    exp_q.push_back({dut, la, wr, run, t});
    name_q.push_back(name);
  endtask

  task automatic pulse_tick();
    tick_in = 1'b0;
    step();
    tick_in = 1'b1;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  task automatic pulse_start_stop();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
  endtask

  // Monitor: compares every pending expectation against the addressed instance
  always @(negedge clk_in) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      case (mon_e[28:27])
        2'd0:    mon_act = {lap_active_a, wrap_a, running_a, time_a};
        2'd1:    mon_act = {lap_active_b, wrap_b, running_b, time_b};
        default: mon_act = {lap_active_c, wrap_c, running_c, time_c};
      endcase
      tests_run++;
      if (mon_act !== mon_e[26:0]) begin
        tests_failed++;
        $display("FAIL %s: got time=%h run=%b wrap=%b lap=%b, expected time=%h run=%b wrap=%b lap=%b",
                 mon_n, mon_act[23:0], mon_act[24], mon_act[25], mon_act[26],
                 mon_e[23:0], mon_e[24], mon_e[25], mon_e[26]);
      end
    end
  end

  initial begin
    rst = 1'b1; tick_in = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    expect_out(2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, "reset_a");
    expect_out(2'd1, 24'h000000, 1'b0, 1'b0, 1'b0, "reset_b");
    expect_out(2'd2, 24'h000000, 1'b0, 1'b0, 1'b0, "reset_c");

    pulse_start_stop();
    ticks(150);
    expect_out(2'd0, 24'h000150, 1'b1, 1'b0, 1'b0, "count_150");

    ticks(5849);
    expect_out(2'd0, 24'h005999, 1'b1, 1'b0, 1'b0, "at_00_59_99");
    ticks(1);
    expect_out(2'd0, 24'h010000, 1'b1, 1'b0, 1'b0, "minute_carry");

    ticks(5999);
    expect_out(2'd1, 24'h015999, 1'b1, 1'b0, 1'b0, "b_at_limit");
    expect_out(2'd2, 24'h015999, 1'b1, 1'b0, 1'b0, "c_at_limit");
    ticks(1);
    expect_out(2'd0, 24'h020000, 1'b1, 1'b0, 1'b0, "a_past_limit");
    expect_out(2'd1, 24'h000000, 1'b1, 1'b1, 1'b0, "b_rollover");
    expect_out(2'd2, 24'h015999, 1'b0, 1'b1, 1'b0, "c_saturate");
    step();
    expect_out(2'd1, 24'h000000, 1'b1, 1'b0, 1'b0, "b_wrap_one_cycle");
    expect_out(2'd2, 24'h015999, 1'b0, 1'b0, 1'b0, "c_wrap_one_cycle");
    ticks(1);
    expect_out(2'd2, 24'h015999, 1'b0, 1'b0, 1'b0, "c_stays_paused");

    // clear coinciding with a tick edge
    tick_in = 1'b0;
    step();
    tick_in = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    expect_out(2'd0, 24'h000000, 1'b0, 1'b0, 1'b0, "clear_with_tick");

    pulse_start_stop();
    ticks(3);
    expect_out(2'd0, 24'h000003, 1'b1, 1'b0, 1'b0, "restart_3");
    pulse_start_stop();
    expect_out(2'd0, 24'h000003, 1'b0, 1'b0, 1'b0, "pause");
    ticks(1);
    expect_out(2'd0, 24'h000003, 1'b0, 1'b0, 1'b0, "paused_no_count");

    // resume coinciding with a tick edge: no increment that cycle
    tick_in = 1'b0;
    step();
    tick_in = 1'b1;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    expect_out(2'd0, 24'h000003, 1'b1, 1'b0, 1'b0, "resume_with_tick");
    ticks(1);
    expect_out(2'd0, 24'h000004, 1'b1, 1'b0, 1'b0, "after_resume");

    // pause coinciding with a tick edge: that tick still counts
    tick_in = 1'b0;
    step();
    tick_in = 1'b1;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    expect_out(2'd0, 24'h000005, 1'b0, 1'b0, 1'b0, "pause_with_tick");

    clear = 1'b1;
    step();
    clear = 1'b0;
    pulse_start_stop();
    ticks(200);
    expect_out(2'd0, 24'h000200, 1'b1, 1'b0, 1'b0, "lap_base");
    lap = 1'b1;
    step();
    lap = 1'b0;
`ifdef CRONOMETRO_LAP_EN
    expect_out(2'd0, 24'h000200, 1'b1, 1'b0, 1'b1, "lap_freeze");
    ticks(100);
    expect_out(2'd0, 24'h000200, 1'b1, 1'b0, 1'b1, "lap_held");
    lap = 1'b1;
    step();
    lap = 1'b0;
    expect_out(2'd0, 24'h000300, 1'b1, 1'b0, 1'b0, "lap_release");
`else
    expect_out(2'd0, 24'h000200, 1'b1, 1'b0, 1'b0, "lap_ignored");
    ticks(100);
    expect_out(2'd0, 24'h000300, 1'b1, 1'b0, 1'b0, "lap_live");
    lap = 1'b1;
    step();
    lap = 1'b0;
    expect_out(2'd0, 24'h000300, 1'b1, 1'b0, 1'b0, "lap_ignored_2");
`endif

    @(negedge clk_in);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cronometro_contador.md
Name: cronometro_contador

Overview:
- Stopwatch time-base counter, directly downstream of the 50 MHz → 100 Hz clock divider; consumes its 100 Hz output as a sampled level, never as a clock.
- Runs entirely on the 50 MHz board clock.
- Counts centiseconds, seconds and minutes in packed BCD (MM:SS.cc) under start/stop/clear control.
- Output feeds the 7-segment display driver.

Parameters:
- MIN_LIMIT, 59: last minute value before roll-over. Legal range 1..99.
- WRAP_STOP, 0: 0 = roll over to 00:00.00 after MIN_LIMIT:59.99; 1 = saturate and go to PAUSED.

Ports:
- clk_in  input  1  50 MHz system clock.
- rst  input  1  synchronous reset, active-high.
- tick_in  input  1  100 Hz square wave from the divider; same clock domain; each rising edge = 10 ms.
- start_stop  input  1  single-cycle pulse from the debouncer; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes time, returns to IDLE.
- lap  input  1  single-cycle pulse; used only with LAP_EN.
- time_bcd  output  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each.
- running  output  1  high while in RUNNING.
- wrap  output  1  one-cycle pulse on roll-over/saturation.
- lap_active  output  1  display frozen (LAP_EN only, else 0).

Behaviour:
- Edge detect:
  - tick_q <= tick_in every cycle; tick_rise = tick_in & ~tick_q.
  - tick_q resets to 1, so no spurious edge after reset.
- FSM states and transitions:
  - IDLE: count = 0. start_stop → RUNNING.
  - RUNNING: start_stop → PAUSED.
  - PAUSED: start_stop → RUNNING.
  - clear: → IDLE from any state.
- Count enable = (state == RUNNING) & tick_rise, evaluated on the current state.
  - start_stop and tick_rise in the same cycle: the tick counts only if leaving RUNNING.
- Latency: time_bcd updates on the clock edge at which tick_rise is high and is visible one cycle after tick_in rises.
- Cascade:
  - cs_u 9→0 carries to cs_t; cs_t 9→0 carries to sec_u; sec_u 9→0 carries to sec_t.
  - sec_t 5→0 (at x9) carries to minutes.
  - Minutes: 00..MIN_LIMIT in BCD.
  - All digits are always valid BCD (0..9); tens-of-seconds 0..5.
- End of range (MIN_LIMIT:59.99 + tick):
  - WRAP_STOP=0: all digits → 0, wrap=1 for one cycle, state stays RUNNING.
  - WRAP_STOP=1: digits hold, wrap=1 for one cycle, state → PAUSED.
- Priority: rst > clear > start_stop / count. clear on the same cycle as tick_rise gives 00:00.00, with no increment.
- Reset / clear mid-operation: takes effect on the next edge. Reset values:
  - time_bcd = 0, running = 0, wrap = 0, lap_active = 0, state = IDLE.
  - Internal live count = 0.
- running: registered, equals (state == RUNNING).

Optional Feature:
- Macro CRONOMETRO_LAP_EN.
- Defined:
  - lap in RUNNING with lap_active=0: snapshot the live count into a display register and set lap_active=1; time_bcd shows the snapshot while counting continues.
  - lap with lap_active=1, or any lap in PAUSED: lap_active=0, display tracks live.
  - clear / rst: lap_active=0.
  - lap in IDLE: ignored.
- Undefined: lap ignored, lap_active tied 0, time_bcd always live; no snapshot register synthesised.

Decomposition:
- Shared package: state encoding (ST_IDLE, ST_RUNNING, ST_PAUSED, 2 bits); BCD digit width (4); digit field offsets within time_bcd.
- One sub-module, bcd_digito: a 4-bit BCD counter with en, clr, configurable terminal value, and carry_out = en & at_terminal. Instantiated six times; minute tens and units are combined by terminal logic for MIN_LIMIT.

Test Plan:
- rst held 3 cycles with tick_in=1, then released → time_bcd=0, running=0, no count on the first cycle.
- start_stop, then 150 tick_in rising edges → time_bcd = 0x000150 (00:01.50); running=1.
- Preload 00:59.99, one tick → 0x010000, no wrap pulse.
- With MIN_LIMIT=59, WRAP_STOP=0, preload 59:59.99, one tick → 0x000000, wrap=1 for exactly 1 cycle, running=1. With WRAP_STOP=1 → holds 0x595999, running=0.
- Simultaneous cases:
  - clear with tick_rise → 0x000000, IDLE.
  - start_stop from PAUSED with tick_rise → value unchanged that cycle.
- CRONOMETRO_LAP_EN, at 00:02.00: lap, then 100 ticks → time_bcd stays 0x000200, lap_active=1; second lap → 0x000300, lap_active=0.
